mbist_march_ctrl: RTL and testbench
===================================

// Module: mbist_march_ctrl
// PURPOSE
//  Parametrised memory BIST engine running March C- over a single-port synchronous SRAM.
//  - Generates address, data and control for every march operation.
//  - Compares read data against expected data through a latency-matched pipe.
//  - Reports busy/done/fail; sits between the test-access logic and the memory wrapper mux.
// PARAMETERS
//  ADDR_W  8  memory address width; depth = 2**ADDR_W
//  DATA_W  8  memory word width; backgrounds are all-0 / all-1
//  RD_LAT  1  memory read latency in cycles (1..4)
//  FCNT_W  8  width of the saturating fail counter (diagnostic build only)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  start      in   1       1-cycle request; accepted only when busy=0
//  busy       out  1       test running (including read drain)
//  done       out  1       high from test end until next accepted start
//  fail       out  1       sticky mismatch flag; cleared on accepted start
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       1 = write, 0 = read (valid when mem_en=1)
//  mem_addr   out  ADDR_W  access address
//  mem_wdata  out  DATA_W  write data
//  mem_rdata  in   DATA_W  read data, valid RD_LAT cycles after a read strobe
//  fail_addr  out  ADDR_W  address of first mismatch (MBIST_FAIL_LOG_EN)
//  fail_elem  out  3       march element index of first mismatch (MBIST_FAIL_LOG_EN)
//  fail_cnt   out  FCNT_W  mismatch count, saturating at all-ones (MBIST_FAIL_LOG_EN)
// BEHAVIOUR
//  Reset: synchronous, active-high on clk. FSM to IDLE; every output 0; read pipe flushed.
//    Reset mid-test aborts immediately; no done.
//  FSM states: IDLE -> RUN -> DRAIN -> DONE -> (start) RUN.
//  March elements:
//    M0 up(w0)
//    M1 up(r0,w1)
//    M2 up(r1,w0)
//    M3 down(r0,w1)
//    M4 down(r1,w0)
//    M5 down(r0)
//  Access timing:
//    - One access per cycle; mem_en=1 every RUN cycle.
//    - A read-then-write pair targets the same address on consecutive cycles.
//  Address sequencing:
//    - up runs 0 -> 2**ADDR_W-1; down runs 2**ADDR_W-1 -> 0.
//    - Element change occurs on terminal address; no extra idle cycle.
//  RUN length: exactly 10*2**ADDR_W cycles.
//  DRAIN: lasts RD_LAT cycles with mem_en=0, so the last read is compared. Then DONE: done=1, busy=0.
//  Compare: each read pushes {valid, expected, addr, elem} into an RD_LAT-deep pipe.
//    Mismatch = pipe valid && mem_rdata != expected. On mismatch, fail=1 next cycle.
//  Start handling:
//    - start while busy is ignored.
//    - start in IDLE or DONE clears done/fail/log and enters RUN at M0, addr 0 the next cycle.
//  Reset has priority over start in the same cycle.
// CONFIGURATION
//  MBIST_FAIL_LOG_EN defined:
//    - fail_addr/fail_elem capture the first mismatch only; later mismatches are not captured.
//    - fail_cnt increments on every mismatch, saturating; simultaneous capture and count are allowed.
//  Not defined: fail_addr, fail_elem and fail_cnt are tied to 0 and no log registers are built.
// STRUCTURE
//  mbist_pkg:
//    - march element enum M0..M5
//    - per-element table: direction, op count, read/expect value, write value
//    - state enum
//  Sub-module mbist_rd_pipe: RD_LAT-deep shift register for valid/expected/addr/elem, flushed by rst.
// TESTING
//  ADDR_W=4, DATA_W=8, RD_LAT=1, fault-free memory model:
//    start -> busy for 161 cycles, done=1, fail=0, fail_cnt=0.
//  Stuck-at-1 on bit0 of addr 5 -> fail=1, fail_addr=5, fail_elem=1 (M1 r0).
//    With MBIST_FAIL_LOG_EN: fail_cnt=3 (M1, M3, M5 reads).
//  RD_LAT=3, same stuck-at fault -> identical fail_addr/fail_elem; busy for 163 cycles.
//  Assert rst at cycle 50 of RUN -> next cycle all outputs 0 and state IDLE; restart completes normally.
//  start pulsed while busy -> ignored, total length unchanged.
//    start in DONE -> done and fail clear, rerun.
//  Address-decoder coupling (addr 3 write also hits addr 11):
//    - fail=1 and fail_elem in {1..4}.
//    - Check mem_addr order: 0..15 ascending for M0-M2, then 15..0 descending for M3-M5.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types for the March C- BIST engine: march element table and FSM state encoding.
package mbist_pkg;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       down;
        logic [1:0] n_ops;
        logic       has_rd;
        logic       rd_val;
        logic       wr_val;
    } elem_cfg_t;

    // March C-: a read (when present) always precedes the write at the same address.
    function automatic elem_cfg_t elem_cfg(input elem_t e);
        elem_cfg_t c;
        case (e)
            M0:      c = '{down: 1'b0, n_ops: 2'd1, has_rd: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
            M1:      c = '{down: 1'b0, n_ops: 2'd2, has_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            M2:      c = '{down: 1'b0, n_ops: 2'd2, has_rd: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            M3:      c = '{down: 1'b1, n_ops: 2'd2, has_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            M4:      c = '{down: 1'b1, n_ops: 2'd2, has_rd: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            M5:      c = '{down: 1'b1, n_ops: 2'd1, has_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
            default: c = '{down: 1'b0, n_ops: 2'd0, has_rd: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mbist_rd_pipe.sv
// Latency-matching pipe carrying read tags (valid, expected data, address, element)
// alongside the memory read path so each returning word meets its own expectation.
module mbist_rd_pipe #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_exp,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [2:0]        in_elem,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_exp,
    output logic [ADDR_W-1:0] out_addr,
    output logic [2:0]        out_elem
);

    logic [DEPTH-1:0]  valid_r;
    logic [DATA_W-1:0] exp_r  [DEPTH];
    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [2:0]        elem_r [DEPTH];

    // Shift register; reset flushes every stage so an aborted test leaves no stale reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                exp_r[i]   <= {DATA_W{1'b0}};
                addr_r[i]  <= {ADDR_W{1'b0}};
                elem_r[i]  <= 3'd0;
            end
        end else begin
            valid_r[0] <= in_valid;
            exp_r[0]   <= in_exp;
            addr_r[0]  <= in_addr;
            elem_r[0]  <= in_elem;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                exp_r[i]   <= exp_r[i-1];
                addr_r[i]  <= addr_r[i-1];
                elem_r[i]  <= elem_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_exp   = exp_r[DEPTH-1];
    assign out_addr  = addr_r[DEPTH-1];
    assign out_elem  = elem_r[DEPTH-1];

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST engine for a single-port synchronous SRAM.
// Define MBIST_FAIL_LOG_EN to build the first-fail address/element capture and fail counter.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [FCNT_W-1:0] fail_cnt
);

    state_t            state_r, state_next_s;
    elem_t             elem_r;
    logic [ADDR_W-1:0] addr_r;
    logic              op_r;
    logic [2:0]        drain_r;
    logic              done_r, fail_r;

    elem_cfg_t         cfg_s, cfg_next_s;
    logic              rd_op_s, op_last_s, at_term_s, run_end_s;
    logic              drain_end_s, start_ok_s, mismatch_s;

    logic              pipe_valid_s;
    logic [DATA_W-1:0] pipe_exp_s;
    logic [ADDR_W-1:0] pipe_addr_s;
    logic [2:0]        pipe_elem_s;

    // Decode of the current element and the position inside it.
    always_comb begin
        cfg_s       = elem_cfg(elem_r);
        cfg_next_s  = elem_cfg(elem_t'(elem_r + 3'd1));
        rd_op_s     = cfg_s.has_rd && !op_r;
        op_last_s   = (cfg_s.n_ops == 2'd1) || op_r;
        at_term_s   = cfg_s.down ? (addr_r == {ADDR_W{1'b0}}) : (addr_r == {ADDR_W{1'b1}});
        run_end_s   = op_last_s && at_term_s && (elem_r == M5);
        drain_end_s = (drain_r == 3'(RD_LAT - 1));
        start_ok_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE));
        mismatch_s  = pipe_valid_s && (mem_rdata != pipe_exp_s);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = start       ? S_RUN   : S_IDLE;
            S_RUN:   state_next_s = run_end_s   ? S_DRAIN : S_RUN;
            S_DRAIN: state_next_s = drain_end_s ? S_DONE  : S_DRAIN;
            S_DONE:  state_next_s = start       ? S_RUN   : S_DONE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM outputs: one memory access per RUN cycle, nothing outside RUN.
    always_comb begin
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        case (state_r)
            S_RUN: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = !rd_op_s;
                mem_addr  = addr_r;
                mem_wdata = rd_op_s ? {DATA_W{1'b0}} : {DATA_W{cfg_s.wr_val}};
            end
            S_DRAIN: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Address/element sequencing, drain timer and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_r  <= M0;
            addr_r  <= {ADDR_W{1'b0}};
            op_r    <= 1'b0;
            drain_r <= 3'd0;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
        end else if (start_ok_s) begin
            elem_r  <= M0;
            addr_r  <= {ADDR_W{1'b0}};
            op_r    <= 1'b0;
            drain_r <= 3'd0;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
        end else begin
            if (state_r == S_RUN) begin
                if (!op_last_s) begin
                    op_r <= 1'b1;
                end else begin
                    op_r <= 1'b0;
                    // Terminal address hands over directly to the next element's start address.
                    if (at_term_s) begin
                        if (elem_r != M5) begin
                            elem_r <= elem_t'(elem_r + 3'd1);
                            addr_r <= cfg_next_s.down ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
                        end
                    end else if (cfg_s.down) begin
                        addr_r <= addr_r - ADDR_W'(1'b1);
                    end else begin
                        addr_r <= addr_r + ADDR_W'(1'b1);
                    end
                end
            end
            drain_r <= (state_r == S_DRAIN) ? drain_r + 3'd1 : 3'd0;
            if ((state_r == S_DRAIN) && drain_end_s) begin
                done_r <= 1'b1;
            end
            if (mismatch_s) begin
                fail_r <= 1'b1;
            end
        end
    end

    assign done = done_r;
    assign fail = fail_r;

    mbist_rd_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  ((state_r == S_RUN) && rd_op_s),
        .in_exp    ({DATA_W{cfg_s.rd_val}}),
        .in_addr   (addr_r),
        .in_elem   (3'(elem_r)),
        .out_valid (pipe_valid_s),
        .out_exp   (pipe_exp_s),
        .out_addr  (pipe_addr_s),
        .out_elem  (pipe_elem_s)
    );

`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] fail_addr_r;
    logic [2:0]        fail_elem_r;
    logic [FCNT_W-1:0] fail_cnt_r;

    // First-fail capture keys off fail_r, which is still low on the first mismatch cycle.
    always_ff @(posedge clk) begin
        if (rst || start_ok_s) begin
            fail_addr_r <= {ADDR_W{1'b0}};
            fail_elem_r <= 3'd0;
            fail_cnt_r  <= {FCNT_W{1'b0}};
        end else if (mismatch_s) begin
            if (!fail_r) begin
                fail_addr_r <= pipe_addr_s;
                fail_elem_r <= pipe_elem_s;
            end
            if (fail_cnt_r != {FCNT_W{1'b1}}) begin
                fail_cnt_r <= fail_cnt_r + FCNT_W'(1'b1);
            end
        end
    end

    assign fail_addr = fail_addr_r;
    assign fail_elem = fail_elem_r;
    assign fail_cnt  = fail_cnt_r;
`else
    logic unused_tag_s;
    assign unused_tag_s = ^{pipe_addr_s, pipe_elem_s};

    assign fail_addr = {ADDR_W{1'b0}};
    assign fail_elem = 3'd0;
    assign fail_cnt  = {FCNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (read latency 1 and 3) on behavioural SRAMs with injectable faults.
module tb_mbist_march_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N_OPS = 160;
`ifdef MBIST_FAIL_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    localparam int EL_DOWN [6] = '{0, 0, 0, 1, 1, 1};
    localparam int EL_RD   [6] = '{-1, 0, 1, 0, 1, 0};
    localparam int EL_WR   [6] = '{0, 1, 0, 1, 0, -1};

    logic clk = 1'b0;
    logic rst, start;

    logic          busy_a, done_a, fail_a, mem_en_a, mem_we_a;
    logic [AW-1:0] mem_addr_a, fail_addr_a;
    logic [DW-1:0] mem_wdata_a, mem_rdata_a;
    logic [2:0]    fail_elem_a;
    logic [7:0]    fail_cnt_a;

    logic          busy_b, done_b, fail_b, mem_en_b, mem_we_b;
    logic [AW-1:0] mem_addr_b, fail_addr_b;
    logic [DW-1:0] mem_wdata_b, mem_rdata_b;
    logic [2:0]    fail_elem_b;
    logic [7:0]    fail_cnt_b;

    int            ftype;
    logic [AW-1:0] f_addr, c_src, c_dst;
    int            f_bit;
    logic          f_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            elem;
    } op_t;

    typedef struct {
        int            ftype;
        logic [AW-1:0] faddr;
        int            fbit;
        logic          fval;
        logic [AW-1:0] csrc;
        logic [AW-1:0] cdst;
        bit            mid_start;
        bit            efail;
        logic [AW-1:0] efaddr;
        int            efelem;
        int            efcnt;
    } vec_t;

    op_t  ops[$];
    op_t  tr[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .FCNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a), .fail(fail_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a), .fail_addr(fail_addr_a), .fail_elem(fail_elem_a), .fail_cnt(fail_cnt_a)
    );

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .FCNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b), .fail(fail_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_cnt(fail_cnt_b)
    );

    // Stuck-at fault is applied on the read path of the faulty cell.
    function automatic logic [7:0] rd_fault(input logic [AW-1:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (ftype == 1 && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    // SRAM model A: read latency 1; coupling fault mirrors writes of c_src into c_dst.
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] rd_a;
    always @(posedge clk) begin
        if (mem_en_a && mem_we_a) begin
            mem_a[mem_addr_a] <= mem_wdata_a;
            if (ftype == 2 && mem_addr_a == c_src) mem_a[c_dst] <= mem_wdata_a;
        end
        if (mem_en_a && !mem_we_a) rd_a <= rd_fault(mem_addr_a, mem_a[mem_addr_a]);
    end
    assign mem_rdata_a = rd_a;

    // SRAM model B: read latency 3.
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] rp_b [3];
    always @(posedge clk) begin
        if (mem_en_b && mem_we_b) begin
            mem_b[mem_addr_b] <= mem_wdata_b;
            if (ftype == 2 && mem_addr_b == c_src) mem_b[c_dst] <= mem_wdata_b;
        end
        rp_b[0] <= (mem_en_b && !mem_we_b) ? rd_fault(mem_addr_b, mem_b[mem_addr_b]) : 8'h00;
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end
    assign mem_rdata_b = rp_b[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected access list straight from the March C- element table.
    task automatic build_ops();
        op_t o;
        ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 16; k++) begin
                o.addr = AW'((EL_DOWN[e] != 0) ? 15 - k : k);
                o.elem = e;
                if (EL_RD[e] >= 0) begin
                    o.we = 1'b0; o.data = (EL_RD[e] == 1) ? 8'hFF : 8'h00; ops.push_back(o);
                end
                if (EL_WR[e] >= 0) begin
                    o.we = 1'b1; o.data = (EL_WR[e] == 1) ? 8'hFF : 8'h00; ops.push_back(o);
                end
            end
        end
    endtask

    // Replays the access list on an ideal memory with the current fault to predict the outcome.
    task automatic model_run(output bit mf, output logic [AW-1:0] ma, output int me, output int mc);
        logic [7:0] mm [16];
        logic [7:0] got;
        mf = 1'b0; ma = '0; me = 0; mc = 0;
        for (int i = 0; i < 16; i++) mm[i] = 8'h00;
        foreach (ops[i]) begin
            if (ops[i].we) begin
                mm[ops[i].addr] = ops[i].data;
                if (ftype == 2 && ops[i].addr == c_src) mm[c_dst] = ops[i].data;
            end else begin
                got = rd_fault(ops[i].addr, mm[ops[i].addr]);
                if (got != ops[i].data) begin
                    if (!mf) begin ma = ops[i].addr; me = ops[i].elem; end
                    mf = 1'b1;
                    mc++;
                end
            end
        end
    endtask

    task automatic run_test(input bit mid, input bit efail, input logic [AW-1:0] efaddr,
                            input int efelem, input int efcnt);
        int ba, bb, bad, n;
        op_t o;
        tr.delete();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        chk("start_clears_done", done_a, 0);
        chk("start_clears_fail", fail_a, 0);
        chk("start_clears_fcnt", fail_cnt_a, 0);
        ba = 0; bb = 0;
        for (int c = 0; c < 600; c++) begin
            if (busy_a) ba++;
            if (busy_b) bb++;
            if (mem_en_a) begin
                o.we = mem_we_a; o.addr = mem_addr_a; o.data = mem_wdata_a; o.elem = 0;
                tr.push_back(o);
            end
            if (done_a && done_b) break;
            start = (mid && c == 40);
            tick();
        end
        start = 1'b0;
        chk("done_a", done_a, 1);
        chk("done_b", done_b, 1);
        chk("busy_len_lat1", ba, 161);
        chk("busy_len_lat3", bb, 163);
        chk("access_count", tr.size(), N_OPS);
        bad = 0;
        n = (tr.size() < N_OPS) ? tr.size() : N_OPS;
        for (int i = 0; i < n; i++) begin
            if (tr[i].we != ops[i].we || tr[i].addr != ops[i].addr ||
                (ops[i].we && tr[i].data != ops[i].data)) bad++;
        end
        chk("access_sequence", bad, 0);
        chk("fail_a", fail_a, int'(efail));
        chk("fail_b", fail_b, int'(efail));
        chk("fail_addr_a", fail_addr_a, LOG_EN ? int'(efaddr) : 0);
        chk("fail_elem_a", fail_elem_a, LOG_EN ? efelem : 0);
        chk("fail_cnt_a", fail_cnt_a, LOG_EN ? efcnt : 0);
        chk("fail_addr_b", fail_addr_b, LOG_EN ? int'(efaddr) : 0);
        chk("fail_elem_b", fail_elem_b, LOG_EN ? efelem : 0);
        chk("fail_cnt_b", fail_cnt_b, LOG_EN ? efcnt : 0);
        tick();
        chk("done_sticky", done_a, 1);
        chk("idle_after_done", int'({busy_a, mem_en_a}), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            mf;
        logic [AW-1:0] ma;
        int            me, mc;

        vecs[0] = '{0, 4'd0, 0, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 4'd0,  0, 0};
        vecs[1] = '{1, 4'd5, 0, 1'b1, 4'd0, 4'd0,  1'b0, 1'b1, 4'd5,  1, 3};
        vecs[2] = '{0, 4'd0, 0, 1'b0, 4'd0, 4'd0,  1'b1, 1'b0, 4'd0,  0, 0};
        vecs[3] = '{2, 4'd0, 0, 1'b0, 4'd3, 4'd11, 1'b0, 1'b1, 4'd11, 1, 2};
        vecs[4] = '{1, 4'd0, 7, 1'b0, 4'd0, 4'd0,  1'b0, 1'b1, 4'd0,  2, 2};

        build_ops();
        ftype = 0; f_addr = '0; f_bit = 0; f_val = 1'b0; c_src = '0; c_dst = '0;
        rst = 1'b1; start = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", int'({busy_a, done_a, fail_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a}), 0);
        chk("reset_log", int'({fail_addr_a, fail_elem_a, fail_cnt_a}), 0);
        rst = 1'b0;

        // Reset 50 cycles into RUN aborts at once.
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        repeat (50) tick();
        chk("midrun_busy", busy_a, 1);
        rst = 1'b1;
        tick();
        chk("abort_outputs_a", int'({busy_a, done_a, fail_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a}), 0);
        chk("abort_outputs_b", int'({busy_b, done_b, fail_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b}), 0);
        // Reset wins over a simultaneous start.
        start = 1'b1;
        tick();
        chk("rst_over_start", int'({busy_a, busy_b}), 0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("stay_idle", int'({busy_a, done_a}), 0);

        for (int v = 0; v < 5; v++) begin
            ftype = vecs[v].ftype; f_addr = vecs[v].faddr; f_bit = vecs[v].fbit;
            f_val = vecs[v].fval; c_src = vecs[v].csrc; c_dst = vecs[v].cdst;
            model_run(mf, ma, me, mc);
            chk("model_vs_table", int'({mf, ma}) * 64 + me * 8 + mc, int'({vecs[v].efail, vecs[v].efaddr}) * 64 + vecs[v].efelem * 8 + vecs[v].efcnt);
            run_test(vecs[v].mid_start, vecs[v].efail, vecs[v].efaddr, vecs[v].efelem, vecs[v].efcnt);
        end

        for (int r = 0; r < 6; r++) begin
            ftype  = int'($urandom_range(0, 2));
            f_addr = AW'($urandom_range(0, 15));
            f_bit  = int'($urandom_range(0, 7));
            f_val  = 1'($urandom_range(0, 1));
            c_src  = AW'($urandom_range(0, 15));
            c_dst  = c_src + AW'($urandom_range(1, 15));
            model_run(mf, ma, me, mc);
            run_test(1'($urandom_range(0, 1)), mf, ma, me, mc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
